// File: rtl/melody_pkg.sv
// Shared encodings for the melody sequencer: FSM states, special tune codes,
// note ROM word layout and the duration decode helper.
// Purely declarative; no logic lives here.
package melody_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_LATCH  = 3'd2;
  localparam logic [2:0] ST_PLAY   = 3'd3;
  localparam logic [2:0] ST_GAP    = 3'd4;
  localparam logic [2:0] ST_PAUSED = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  // Special tune codes
  localparam logic [3:0] TUNE_REST = 4'h0;
  localparam logic [3:0] TUNE_END  = 4'hF;

  // Note ROM word layout: [7:4] duration in beats, [3:0] tune code
  localparam int DUR_MSB  = 7;
  localparam int DUR_LSB  = 4;
  localparam int CODE_MSB = 3;
  localparam int CODE_LSB = 0;

  // Width of the inter-note gap counter
  localparam int GAP_W = 8;

  // A zero duration would never terminate, so it plays for a single beat.
  function automatic logic [3:0] note_dur(input logic [7:0] word);
    logic [3:0] dur;
    dur = word[DUR_MSB:DUR_LSB];
    return (dur == 4'd0) ? 4'd1 : dur;
  endfunction

endpackage

// File: rtl/melody_sequencer_beat_tick_sync.sv
// Purpose: bring the slow beat clock into clk and emit a one-cycle tick per rising edge.
// Latency: tick is high in the third clk cycle after the rising level is first sampled.
// Backpressure: none; ticks are free-running and consumed or dropped by the sequencer.
module beat_tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic beat_clk,
  output logic tick
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic tick_q,  tick_d;

  // Two-flop synchronizer, edge-detect history and registered rising-edge pulse
  always_comb begin
    sync1_d = beat_clk;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    tick_d  = sync2_q & ~prev_q;
  end

  // State update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/melody_sequencer.sv
// Purpose: walk the note ROM, time each note in beats and drive tune code plus onset pulse.
// Latency: play_req (or a note's final tick) -> FETCH -> LATCH -> tune/note_start 3 cycles later.
// Backpressure: none; play/stop are pulses, play in FETCH/LATCH is deferred until PLAY.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int GAP_TICKS = 0,
  parameter int LOOP      = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_clk,
  input  logic              play_req,
  input  logic              stop_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [3:0]        tune_code,
  output logic              note_start,
  output logic              playing,
  output logic              song_done
);

  logic tick;

  beat_tick_sync u_tick (
    .clk      (clk),
    .rst      (rst),
    .beat_clk (beat_clk),
    .tick     (tick)
  );

  logic [2:0]        state_q, state_d;
  logic [2:0]        ret_q, ret_d;            // state to resume into after PAUSED
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [3:0]        tune_q, tune_d;          // tune currently driven (0 while silent)
  logic [3:0]        cur_tune_q, cur_tune_d;  // tune of the note in progress, for resume
  logic              note_start_q, note_start_d;
  logic [3:0]        remain_q, remain_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              pend_q, pend_d;          // play_req seen during FETCH/LATCH

  logic              adv;      // current note (and gap) finished: move to next address
  logic              fin;      // end marker decoded
  logic              at_last;  // no address beyond the current one
  logic [3:0]        code;

  assign at_last = (rom_addr_q == {ADDR_W{1'b1}});
  assign code    = rom_data[CODE_MSB:CODE_LSB];

  // Next-state logic: stop overrides everything, pause beats a coincident tick
  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    rom_addr_d   = rom_addr_q;
    tune_d       = tune_q;
    cur_tune_d   = cur_tune_q;
    note_start_d = 1'b0;
    remain_d     = remain_q;
    gap_d        = gap_q;
    pend_d       = pend_q;
    adv          = 1'b0;
    fin          = 1'b0;

    if (stop_req) begin
      state_d    = ST_IDLE;
      rom_addr_d = '0;
      tune_d     = TUNE_REST;
      pend_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (play_req) begin
            rom_addr_d = '0;
            state_d    = ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (play_req) pend_d = 1'b1;
          state_d = ST_LATCH;
        end
        ST_LATCH: begin
          if (play_req) pend_d = 1'b1;
          if (code == TUNE_END) begin
            fin = 1'b1;
          end else begin
            tune_d       = code;
            cur_tune_d   = code;
            note_start_d = 1'b1;
            remain_d     = note_dur(rom_data);
            state_d      = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (play_req || pend_q) begin
            pend_d  = 1'b0;
            ret_d   = ST_PLAY;
            tune_d  = TUNE_REST;
            state_d = ST_PAUSED;
          end else if (tick) begin
            if (remain_q <= 4'd1) begin
              if (GAP_TICKS > 0) begin
                tune_d  = TUNE_REST;
                gap_d   = GAP_W'(GAP_TICKS);
                state_d = ST_GAP;
              end else begin
                adv = 1'b1;
              end
            end else begin
              remain_d = remain_q - 4'd1;
            end
          end
        end
        ST_GAP: begin
          if (play_req) begin
            ret_d   = ST_GAP;
            state_d = ST_PAUSED;
          end else if (tick) begin
            if (gap_q <= GAP_W'(1)) adv = 1'b1;
            else                    gap_d = gap_q - GAP_W'(1);
          end
        end
        ST_PAUSED: begin
          if (play_req) begin
            state_d = ret_q;
            tune_d  = (ret_q == ST_PLAY) ? cur_tune_q : TUNE_REST;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // Step to the next entry; running off the end of the ROM counts as an end marker
      if (adv && !at_last) begin
        rom_addr_d = rom_addr_q + ADDR_W'(1);
        state_d    = ST_FETCH;
      end
      if (fin || (adv && at_last)) begin
        if (LOOP != 0) begin
          rom_addr_d = '0;
          state_d    = ST_FETCH;
        end else begin
          tune_d  = TUNE_REST;
          pend_d  = 1'b0;
          state_d = ST_DONE;
        end
      end
    end
  end

  // Register all sequencer state; reset returns to IDLE silently
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ret_q        <= ST_PLAY;
      rom_addr_q   <= '0;
      tune_q       <= TUNE_REST;
      cur_tune_q   <= TUNE_REST;
      note_start_q <= 1'b0;
      remain_q     <= 4'd0;
      gap_q        <= '0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      rom_addr_q   <= rom_addr_d;
      tune_q       <= tune_d;
      cur_tune_q   <= cur_tune_d;
      note_start_q <= note_start_d;
      remain_q     <= remain_d;
      gap_q        <= gap_d;
      pend_q       <= pend_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign tune_code  = tune_q;
  assign note_start = note_start_q;
  assign playing    = (state_q == ST_FETCH) || (state_q == ST_LATCH) ||
                      (state_q == ST_PLAY)  || (state_q == ST_GAP);
  assign song_done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer: four instances cover the default,
// gap, loop and small-ROM configurations, sharing clock, reset and beat clock.
module tb_melody_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic beat_clk = 1'b0;

  always #5 clk = ~clk;

  // Default instance (a), GAP_TICKS=1 (g), LOOP=1 (l), ADDR_W=2 (s)
  logic       play_a = 0, stop_a = 0, ns_a, pl_a, dn_a;
  logic       play_g = 0, stop_g = 0, ns_g, pl_g, dn_g;
  logic       play_l = 0, stop_l = 0, ns_l, pl_l, dn_l;
  logic       play_s = 0, stop_s = 0, ns_s, pl_s, dn_s;
  logic [5:0] addr_a, addr_g, addr_l;
  logic [1:0] addr_s;
  logic [7:0] data_a = 0, data_g = 0, data_l = 0, data_s = 0;
  logic [3:0] tune_a, tune_g, tune_l, tune_s;

  logic [7:0] rom_a [64];
  logic [7:0] rom_g [64];
  logic [7:0] rom_l [64];
  logic [7:0] rom_s [4];

  melody_sequencer u_a (
    .clk(clk), .rst(rst), .beat_clk(beat_clk), .play_req(play_a), .stop_req(stop_a),
    .rom_addr(addr_a), .rom_data(data_a), .tune_code(tune_a), .note_start(ns_a),
    .playing(pl_a), .song_done(dn_a));

  melody_sequencer #(.GAP_TICKS(1)) u_g (
    .clk(clk), .rst(rst), .beat_clk(beat_clk), .play_req(play_g), .stop_req(stop_g),
    .rom_addr(addr_g), .rom_data(data_g), .tune_code(tune_g), .note_start(ns_g),
    .playing(pl_g), .song_done(dn_g));

  melody_sequencer #(.LOOP(1)) u_l (
    .clk(clk), .rst(rst), .beat_clk(beat_clk), .play_req(play_l), .stop_req(stop_l),
    .rom_addr(addr_l), .rom_data(data_l), .tune_code(tune_l), .note_start(ns_l),
    .playing(pl_l), .song_done(dn_l));

  melody_sequencer #(.ADDR_W(2)) u_s (
    .clk(clk), .rst(rst), .beat_clk(beat_clk), .play_req(play_s), .stop_req(stop_s),
    .rom_addr(addr_s), .rom_data(data_s), .tune_code(tune_s), .note_start(ns_s),
    .playing(pl_s), .song_done(dn_s));

  // Registered note ROMs: data valid one cycle after address
  always @(posedge clk) begin
    data_a <= rom_a[addr_a];
    data_g <= rom_g[addr_g];
    data_l <= rom_l[addr_l];
    data_s <= rom_s[addr_s];
  end

  // Onset counters, pulse-width watch and loop observations
  int  cnt_a = 0, cnt_g = 0, cnt_l = 0, cnt_s = 0;
  int  wide_cnt = 0;
  logic prev_a = 0, prev_g = 0, prev_l = 0, prev_s = 0;
  logic saw_addr1_l = 0, saw_done_l = 0;

  always @(posedge clk) begin
    if (ns_a) cnt_a <= cnt_a + 1;
    if (ns_g) cnt_g <= cnt_g + 1;
    if (ns_l) cnt_l <= cnt_l + 1;
    if (ns_s) cnt_s <= cnt_s + 1;
    if ((ns_a && prev_a) || (ns_g && prev_g) || (ns_l && prev_l) || (ns_s && prev_s))
      wide_cnt <= wide_cnt + 1;
    prev_a <= ns_a; prev_g <= ns_g; prev_l <= ns_l; prev_s <= ns_s;
    if (addr_l == 6'd1) saw_addr1_l <= 1'b1;
    if (dn_l) saw_done_l <= 1'b1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic play_pulse(input int i);
    @(negedge clk);
    case (i)
      0: play_a = 1'b1;
      1: play_g = 1'b1;
      2: play_l = 1'b1;
      default: play_s = 1'b1;
    endcase
    @(negedge clk);
    play_a = 1'b0; play_g = 1'b0; play_l = 1'b0; play_s = 1'b0;
  endtask

  task automatic stop_pulse(input int i);
    @(negedge clk);
    case (i)
      0: stop_a = 1'b1;
      1: stop_g = 1'b1;
      2: stop_l = 1'b1;
      default: stop_s = 1'b1;
    endcase
    @(negedge clk);
    stop_a = 1'b0; stop_g = 1'b0; stop_l = 1'b0; stop_s = 1'b0;
  endtask

  // play_req and wait until the first note has started
  task automatic start(input int i);
    play_pulse(i);
    repeat (3) @(negedge clk);
  endtask

  // One beat period: long enough for tick, refetch (even through a loop wrap) and onset
  task automatic beat();
    @(negedge clk);
    beat_clk = 1'b1;
    repeat (8) @(negedge clk);
    beat_clk = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  int base;

  initial begin
    for (int k = 0; k < 64; k++) begin
      rom_a[k] = 8'h0F; rom_g[k] = 8'h0F; rom_l[k] = 8'h0F;
    end
    for (int k = 0; k < 4; k++) rom_s[k] = 8'h0F;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tune", tune_a, 0);
    check("rst_ns", ns_a, 0);
    check("rst_playing", pl_a, 0);
    check("rst_done", dn_a, 0);
    check("rst_addr", addr_a, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic song {23,15,0F}: onset latency and note durations
    rom_a[0] = 8'h23; rom_a[1] = 8'h15; rom_a[2] = 8'h0F;
    play_pulse(0);
    check("t1_fetch_playing", pl_a, 1);
    check("t1_fetch_ns", ns_a, 0);
    @(negedge clk);
    check("t1_latch_ns", ns_a, 0);
    @(negedge clk);
    check("t1_onset_ns", ns_a, 1);
    check("t1_onset_tune", tune_a, 3);
    @(negedge clk);
    check("t1_ns_width", ns_a, 0);
    beat();
    check("t1_b1_tune", tune_a, 3);
    beat();
    check("t1_b2_tune", tune_a, 5);
    check("t1_b2_addr", addr_a, 1);
    check("t1_b2_cnt", cnt_a, 2);
    beat();
    check("t1_done", dn_a, 1);
    check("t1_done_tune", tune_a, 0);
    check("t1_done_playing", pl_a, 0);
    check("t1_cnt", cnt_a, 2);

    // Pause/resume during note 0x45
    rom_a[0] = 8'h45; rom_a[1] = 8'h0F;
    base = cnt_a;
    start(0);
    check("t2_done_cleared", dn_a, 0);
    check("t2_tune", tune_a, 5);
    beat();
    check("t2_b1_tune", tune_a, 5);
    play_pulse(0);
    check("t2_pause_tune", tune_a, 0);
    check("t2_pause_playing", pl_a, 0);
    beat(); beat(); beat();
    check("t2_paused_tune", tune_a, 0);
    check("t2_paused_done", dn_a, 0);
    play_pulse(0);
    check("t2_resume_tune", tune_a, 5);
    check("t2_resume_ns", ns_a, 0);
    beat(); beat();
    check("t2_b3_tune", tune_a, 5);
    beat();
    check("t2_end_done", dn_a, 1);
    check("t2_cnt", cnt_a - base, 1);

    // Duration 0 plays one beat
    rom_a[0] = 8'h07;
    start(0);
    check("t3_tune", tune_a, 7);
    beat();
    check("t3_done", dn_a, 1);
    check("t3_tune_off", tune_a, 0);

    // play_req during FETCH is deferred and pauses right after the onset
    rom_a[0] = 8'h23;
    @(negedge clk);
    play_a = 1'b1;
    repeat (2) @(negedge clk);
    play_a = 1'b0;
    @(negedge clk);
    check("t4_onset_ns", ns_a, 1);
    check("t4_onset_tune", tune_a, 3);
    @(negedge clk);
    check("t4_defer_tune", tune_a, 0);
    check("t4_defer_playing", pl_a, 0);
    play_pulse(0);
    check("t4_resume_tune", tune_a, 3);
    stop_pulse(0);
    check("t4_stop_playing", pl_a, 0);

    // stop_req and play_req together mid-song: stop wins
    rom_a[0] = 8'h11; rom_a[1] = 8'h23; rom_a[2] = 8'h0F;
    start(0);
    beat();
    check("t5_tune", tune_a, 3);
    check("t5_addr", addr_a, 1);
    @(negedge clk);
    stop_a = 1'b1; play_a = 1'b1;
    @(negedge clk);
    stop_a = 1'b0; play_a = 1'b0;
    check("t5_stop_playing", pl_a, 0);
    check("t5_stop_tune", tune_a, 0);
    check("t5_stop_addr", addr_a, 0);
    check("t5_stop_done", dn_a, 0);
    beat();
    check("t5_idle_after", pl_a, 0);

    // GAP_TICKS = 1: silent beat after each note
    rom_g[0] = 8'h21; rom_g[1] = 8'h22; rom_g[2] = 8'h0F;
    start(1);
    check("t6_n1", tune_g, 1);
    beat();
    check("t6_n1_b1", tune_g, 1);
    beat();
    check("t6_gap1", tune_g, 0);
    check("t6_gap1_playing", pl_g, 1);
    beat();
    check("t6_n2", tune_g, 2);
    beat();
    check("t6_n2_b1", tune_g, 2);
    beat();
    check("t6_gap2", tune_g, 0);
    check("t6_gap2_done", dn_g, 0);
    beat();
    check("t6_done", dn_g, 1);
    check("t6_cnt", cnt_g, 2);

    // ADDR_W = 2 ROM with no end marker: end after address 3
    rom_s[0] = 8'h11; rom_s[1] = 8'h12; rom_s[2] = 8'h13; rom_s[3] = 8'h14;
    start(3);
    check("t7_n1", tune_s, 1);
    beat();
    check("t7_n2", tune_s, 2);
    beat();
    check("t7_n3", tune_s, 3);
    beat();
    check("t7_n4", tune_s, 4);
    check("t7_addr3", addr_s, 3);
    beat();
    check("t7_done", dn_s, 1);
    check("t7_tune_off", tune_s, 0);
    check("t7_cnt", cnt_s, 4);

    // LOOP = 1: tune 1 repeats forever
    rom_l[0] = 8'h11; rom_l[1] = 8'h0F;
    start(2);
    check("t8_tune", tune_l, 1);
    check("t8_addr", addr_l, 0);
    beat();
    check("t8_b1_tune", tune_l, 1);
    check("t8_b1_addr", addr_l, 0);
    check("t8_b1_cnt", cnt_l, 2);
    beat(); beat();
    check("t8_cnt", cnt_l, 4);
    check("t8_saw_addr1", saw_addr1_l, 1);
    check("t8_never_done", saw_done_l, 0);
    check("t8_playing", pl_l, 1);
    stop_pulse(2);
    check("t8_stop_playing", pl_l, 0);

    check("ns_single_cycle", wide_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Sequences song playback for the wave generator.
- Walks a registered note ROM, where each entry holds a tune code and a duration in beats.
- Times each note against the slow beat clock and drives the wave generator's tune input, plus a one-cycle restart pulse at every note onset.
- Adds play/pause/stop control and an end-of-song indication. Replaces the fixed tick/tune chain in the top level.

Parameters:
- ADDR_W, 6, ROM address width; song length is at most 2**ADDR_W entries.
- GAP_TICKS, 0, number of silent beats inserted between consecutive notes (0 = legato).
- LOOP, 0, 1 = restart from address 0 at end-of-song; 0 = stop in DONE.

Ports:
- clk  in  1  system clock (12 MHz domain).
- rst  in  1  synchronous, active-high reset.
- beat_clk  in  1  slow divided beat clock (4 Hz), asynchronous to clk as a level.
- play_req  in  1  single-cycle pulse: start, pause or resume.
- stop_req  in  1  single-cycle pulse: abort to IDLE.
- rom_addr  out  ADDR_W  note ROM address.
- rom_data  in  8  ROM word; valid one cycle after rom_addr. [7:4] = duration in beats, [3:0] = tune code.
- tune_code  out  4  tune to the wave generator; 0 = rest/silence.
- note_start  out  1  one-cycle pulse at each note onset (wave generator restart).
- playing  out  1  high in FETCH/LATCH/PLAY/GAP.
- song_done  out  1  high in DONE.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - state = IDLE, rom_addr = 0, tune_code = 0, note_start = 0, playing = 0, song_done = 0.
  - beat counter = 0; sync flops = 0.
- Beat tick:
  - beat_clk goes through a 2-flop synchronizer and rising-edge detect, giving a one-cycle tick.
  - Tick is asserted 3 clk cycles after the rising edge is first sampled.
- States: IDLE, FETCH, LATCH, PLAY, GAP, PAUSED, DONE.
- IDLE/DONE + play_req:
  - rom_addr = 0; go to FETCH.
  - Leaving DONE clears song_done.
- FETCH: rom_addr stable for 1 cycle, then go to LATCH.
- LATCH: decode rom_data.
  - Code 4'hF (end marker):
    - LOOP = 1: rom_addr = 0, go to FETCH.
    - LOOP = 0: go to DONE, tune_code = 0.
  - Any other code:
    - tune_code = code, note_start = 1 for exactly one cycle.
    - remaining = duration; a duration of 0 is treated as 1.
    - Go to PLAY.
  - Code 0 is played as a rest (tune 0) with a note_start pulse.
- PLAY: each tick decrements remaining. On the tick where remaining == 1:
  - GAP_TICKS > 0: tune_code = 0, gap counter = GAP_TICKS, go to GAP.
  - GAP_TICKS == 0: rom_addr + 1, go to FETCH.
- GAP: each tick decrements the gap counter; on reaching 0, rom_addr + 1, go to FETCH.
- Address wrap: incrementing past 2**ADDR_W − 1 is treated as an end marker (same LOOP/DONE rule). Never silently wrap to 0 without that rule.
- Latency: play_req in cycle N gives FETCH at N+1, LATCH at N+2, tune_code and note_start valid at N+3. The same 3-cycle spacing applies from the terminating tick to the next onset.
- Pause and resume:
  - play_req in PLAY or GAP enters PAUSED.
    - tune_code forced to 0.
    - remaining, gap counter and return state are held.
    - Ticks are ignored.
  - play_req in PAUSED restores the saved state and tune_code. No note_start pulse is issued; the note continues.
  - play_req in FETCH/LATCH is deferred: latched and applied on entry to PLAY.
- stop_req:
  - From any state, go to IDLE with tune_code = 0 and rom_addr = 0; clears any deferred play_req.
  - stop_req and play_req in the same cycle: stop wins.
- Simultaneous events:
  - A tick during FETCH/LATCH is discarded (beats are ≥ 3M cycles apart).
  - A tick and play_req in the same PLAY cycle: pause wins and the tick is not counted.
- rst mid-operation: immediate return to reset values on that clk edge; no note_start pulse.

Decomposition:
- Package melody_pkg:
  - State enum.
  - TUNE_REST = 4'h0, TUNE_END = 4'hF.
  - Field positions DUR_MSB = 7, DUR_LSB = 4, CODE_MSB = 3, CODE_LSB = 0.
- Sub-module beat_tick_sync: 2-flop synchronizer plus rising-edge pulse, with clk/rst ports.

Test Plan:
- ROM {0x23, 0x15, 0x0F}, play_req -> tune 3 held for 2 ticks, then tune 5 for 1 tick, then DONE. Each note_start is 1 cycle, 3 cycles after its trigger; song_done = 1 and tune_code = 0.
- GAP_TICKS = 1, ROM {0x21, 0x22, 0x0F} -> sequence 1 (2 ticks), 0 (1 tick), 2 (2 ticks), 0 (1 tick), then DONE.
- Pause during note 0x45 after 1 tick -> tune_code = 0 and extra ticks ignored. Resume -> tune 5 returns with no note_start and lasts 3 more ticks.
- LOOP = 1, ROM {0x11, 0x0F} -> tune 1 repeats indefinitely; rom_addr cycles 0, 1, 0; song_done never asserts.
- stop_req and play_req in the same cycle mid-note -> IDLE, tune_code = 0, rom_addr = 0, playing = 0.
- Duration 0 entry 0x07 -> tune 7 lasts 1 tick. ROM full of non-end entries with ADDR_W = 2 -> DONE after address 3.
